iter_cmp_unit: RTL and testbench

- Parametrised multi-cycle comparator for the integer datapath.
- Computes a - b as a subtract (a + ~b + 1) over several clocks, CHUNK bits per clock, LSB chunk first. The carry is kept between chunks.
- Supports unsigned less-than, signed less-than, equal and not-equal.
- Result is a zero-extended 0/1 word in WIDTH bits; valid/ready handshakes on both sides let the ALU stall around it.

---
 rtl/iter_cmp_unit.sv | 164 ++++++++++++++++
 tb/tb_iter_cmp_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_cmp_unit.sv
// Multi-cycle SLTU/SLT/EQ/NE comparator, CHUNK bits of a-b per clock.
// Define ITER_CMP_DIFF_EN to expose the full difference and borrow.
module iter_cmp_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef ITER_CMP_DIFF_EN
  ,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`endif
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("iter_cmp_unit: illegal WIDTH/CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   sum;
  logic             c_n, eq_n, res;

`ifdef ITER_CMP_DIFF_EN
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic [WIDTH+CHUNK-1:0] diff_cat;
  assign diff_cat = {sum[CHUNK-1:0], diff_q};
  assign diff     = diff_q;
  assign borrow   = ~carry_q;
`else
  logic unused_sum;
  assign unused_sum = ^sum[CHUNK-1:0];
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

  always_comb begin
    a_c  = a_q[CHUNK-1:0];
    b_c  = b_q[CHUNK-1:0];
    sum  = {1'b0, a_c} + {1'b0, ~b_c}
         + {{CHUNK{1'b0}}, carry_q};
    c_n  = sum[CHUNK];
    eq_n = eq_q & (a_c == b_c);
    case (op_q)
      2'b00:   res = ~c_n;
      2'b01:   res = (sa_q ^ sb_q) ? sa_q : ~c_n;
      2'b10:   res = eq_n;
      default: res = ~eq_n;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef ITER_CMP_DIFF_EN
    diff_d  = diff_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          carry_d = 1'b1;
          eq_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // operands shift down so chunk i is always in the low CHUNK bits
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = c_n;
        eq_d    = eq_n;
`ifdef ITER_CMP_DIFF_EN
        diff_d  = diff_cat[WIDTH+CHUNK-1:CHUNK];
`endif
        if (cnt_q == LAST) begin
          out_d   = {{(WIDTH-1){1'b0}}, res};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      carry_q <= 1'b1;
      eq_q    <= 1'b1;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef ITER_CMP_DIFF_EN
      diff_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef ITER_CMP_DIFF_EN
      diff_q  <= diff_d;
`endif
    end
  end

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Randomised self-checking bench for iter_cmp_unit in three configurations.
// Optional diff/borrow checks follow ITER_CMP_DIFF_EN.
module tb_iter_cmp_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        ordy;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] o0;
  logic [15:0] o1;
  logic [63:0] o2;
`ifdef ITER_CMP_DIFF_EN
  logic [31:0] d0;
  logic [15:0] d1;
  logic [63:0] d2;
  logic        bo0, bo1, bo2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iter_cmp_unit #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
    .op(op), .a(a[31:0]), .b(b[31:0]),
    .out_valid(ov0), .out_ready(ordy), .out(o0)
`ifdef ITER_CMP_DIFF_EN
    , .diff(d0), .borrow(bo0)
`endif
  );

  iter_cmp_unit #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .op(op), .a(a[15:0]), .b(b[15:0]),
    .out_valid(ov1), .out_ready(ordy), .out(o1)
`ifdef ITER_CMP_DIFF_EN
    , .diff(d1), .borrow(bo1)
`endif
  );

  iter_cmp_unit #(.WIDTH(64), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
    .op(op), .a(a), .b(b),
    .out_valid(ov2), .out_ready(ordy), .out(o2)
`ifdef ITER_CMP_DIFF_EN
    , .diff(d2), .borrow(bo2)
`endif
  );

  function automatic int w_of(input int c);
    return (c == 0) ? 32 : (c == 1) ? 16 : 64;
  endfunction

  function automatic int steps_of(input int c);
    return (c == 0) ? 4 : (c == 1) ? 1 : 16;
  endfunction

  function automatic logic ir_of(input int c);
    return (c == 0) ? ir0 : (c == 1) ? ir1 : ir2;
  endfunction

  function automatic logic ov_of(input int c);
    return (c == 0) ? ov0 : (c == 1) ? ov1 : ov2;
  endfunction

  function automatic logic [63:0] out_of(input int c);
    return (c == 0) ? {32'd0, o0} : (c == 1) ? {48'd0, o1} : o2;
  endfunction

  // Reference: plain integer comparisons on the masked operands
  function automatic logic [63:0] ref_cmp(input int w, input logic [1:0] o,
                                          input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m, msb, xs, ys;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb = 64'd1 << (w - 1);
    xs  = x & m;
    ys  = y & m;
    case (o)
      2'd0:    return {63'd0, xs < ys};
      2'd1:    return {63'd0, (xs ^ msb) < (ys ^ msb)};
      2'd2:    return {63'd0, xs == ys};
      default: return {63'd0, xs != ys};
    endcase
  endfunction

  task automatic do_op(input int c, input logic [1:0] o,
                       input logic [63:0] x, input logic [63:0] y,
                       input int hold, output logic [63:0] r, output int lat);
    op = o; a = x; b = y; iv[c] = 1'b1;
    @(posedge clk); #1;
    iv[c] = 1'b0;
    lat = 0;
    while (!ov_of(c) && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    n_chk++;
    if (ov_of(c) !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout cfg%0d: out_valid=%b required 1", c, ov_of(c));
    end
    r = out_of(c);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; ordy = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (ir_of(c) !== 1'b1 || ov_of(c) !== 1'b0 || out_of(c) !== 64'd0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: ir=%b ov=%b out=%h required 1 0 0",
                 c, ir_of(c), ov_of(c), out_of(c));
      end
    end
  endtask

  task automatic chk_op(input string nm, input logic [1:0] o,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp);
    logic [63:0] r;
    int lat;
    do_op(0, o, x, y, 0, r, lat);
    n_chk++;
    if (r !== exp || lat != 4) begin
      n_fail++;
      $display("FAIL %s: out=%h lat=%0d required out=%h lat=4", nm, r, lat, exp);
    end
  endtask

  task automatic test_sltu();
    chk_op("sltu_5_7", 2'd0, 64'h5, 64'h7, 64'd1);
    chk_op("sltu_7_5", 2'd0, 64'h7, 64'h5, 64'd0);
    chk_op("sltu_m1_1", 2'd0, 64'hFFFF_FFFF, 64'h1, 64'd0);
    chk_op("sltu_min_max", 2'd0, 64'h8000_0000, 64'h7FFF_FFFF, 64'd0);
  endtask

  task automatic test_slt();
    chk_op("slt_m1_1", 2'd1, 64'hFFFF_FFFF, 64'h1, 64'd1);
    chk_op("slt_min_max", 2'd1, 64'h8000_0000, 64'h7FFF_FFFF, 64'd1);
    chk_op("slt_1_m1", 2'd1, 64'h1, 64'hFFFF_FFFF, 64'd0);
  endtask

  task automatic test_eq_ne();
    chk_op("eq_same", 2'd2, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd1);
    chk_op("ne_same", 2'd3, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd0);
    chk_op("ne_diff", 2'd3, 64'hDEAD_BEEF, 64'hDEAD_BEEE, 64'd1);
    chk_op("eq_diff", 2'd2, 64'hDEAD_BEEF, 64'hDEAD_BEEE, 64'd0);
`ifdef ITER_CMP_DIFF_EN
    n_chk++;
    if (d0 !== 32'h1 || bo0 !== 1'b0) begin
      n_fail++;
      $display("FAIL diff: diff=%h borrow=%b required 00000001 0", d0, bo0);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    int k;
    bit stable;
    op = 2'd0; a = 64'h5; b = 64'h7; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    k = 0;
    while (!ov0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    r0 = o0;
    n_chk++;
    if (ov0 !== 1'b1 || r0 !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_result: ov=%b out=%h required 1 00000001", ov0, r0);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'($urandom % 2);
      a = {32'd0, $urandom};
      op = 2'($urandom);
      @(posedge clk); #1;
      if (ov0 !== 1'b1 || o0 !== r0 || ir0 !== 1'b0) stable = 1'b0;
    end
    iv[0] = 1'b0;
    n_chk++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_hold: ov=%b out=%h ir=%b required 1 %h 0", ov0, o0, ir0, r0);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    n_chk++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: ir=%b ov=%b required 1 0", ir0, ov0);
    end
  endtask

  task automatic test_reset_midop();
    bit stale;
    op = 2'd0; a = 64'd3; b = 64'd9; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (ir0 !== 1'b1 || ov0 !== 1'b0 || o0 !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst: ir=%b ov=%b out=%h required 1 0 0", ir0, ov0, o0);
    end
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov0 !== 1'b0) stale = 1'b1;
    end
    n_chk++;
    if (stale) begin
      n_fail++;
      $display("FAIL midrst_stale: out_valid seen 1 required 0");
    end
    chk_op("after_rst_9_3", 2'd0, 64'd9, 64'd3, 64'd0);
  endtask

  task automatic test_random(input int c, input int n);
    logic [63:0] x, y, r, exp;
    logic [1:0] o;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom);
      x = {$urandom, $urandom};
      case ($urandom % 4)
        0:       y = x;
        1:       y = x ^ (64'd1 << ($urandom % w_of(c)));
        2:       y = x ^ (64'd1 << (w_of(c) - 1));
        default: y = {$urandom, $urandom};
      endcase
      exp = ref_cmp(w_of(c), o, x, y);
      do_op(c, o, x, y, int'($urandom % 2), r, lat);
      n_chk++;
      if (r !== exp || lat != steps_of(c)) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL rand cfg%0d op=%0d a=%h b=%h: out=%h lat=%0d required out=%h lat=%0d",
                   c, o, x, y, r, lat, exp, steps_of(c));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sltu();
    test_slt();
    test_eq_ne();
    test_backpressure();
    test_reset_midop();
    test_random(0, 1000);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
